// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the fetch/data SRAM arbiter: source encodings,
// default starvation limit and the packed request-bus width.
package sram_arbiter_pkg;

   typedef enum logic {
      SRC_INST = 1'b0,
      SRC_DATA = 1'b1
   } src_e;

   localparam int STARVE_LIMIT_DEF = 4;
   localparam int STREAK_W         = 4;
   localparam int WE_W             = 4;

   // Width of a {req, we, addr, wdata} request vector carried between stages.
   function automatic int arb_req_w(input int addr_w, input int data_w);
      return 1 + WE_W + addr_w + data_w;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Core-side fetch/data request ports plus the unified SRAM port, bundled for the arbiter.
interface sram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_addr_ok;
   logic              i_data_ok;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic [3:0]        d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_addr_ok;
   logic              d_data_ok;
   logic [DATA_W-1:0] d_rdata;

   logic              sram_en;
   logic [3:0]        sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   logic [31:0]       conflict_cnt;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
      output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
             sram_en, sram_we, sram_addr, sram_wdata, conflict_cnt
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
      input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
             sram_en, sram_we, sram_addr, sram_wdata, conflict_cnt
   );
endinterface

// File: rtl/sram_arb_pick.sv
// Combinational grant selector: data wins unless a pending fetch has waited
// through STARVE_LIMIT consecutive data grants.
module sram_arb_pick
   import sram_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                dreq_i,
   input  logic                ireq_i,
   input  logic [STREAK_W-1:0] streak_i,
   output logic                gnt_dat_o,
   output logic                gnt_ins_o
);
   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

   logic force_ins;

   assign force_ins = ireq_i && (streak_i == LIMIT);
   assign gnt_dat_o = dreq_i && !force_ins;
   assign gnt_ins_o = ireq_i && !gnt_dat_o;
endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data
// access; one grant per cycle, response to its owner on the next cycle.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input logic           clk,
   input logic           reset,
   sram_arbiter_if.slave bus
);
   localparam int                  REQ_W = arb_req_w(ADDR_W, DATA_W);
   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

   logic                rdy_q,      rdy_d;
   logic                resp_vld_q, resp_vld_d;
   src_e                resp_src_q, resp_src_d;
   logic [STREAK_W-1:0] streak_q,   streak_d;
   logic [31:0]         conflict_q, conflict_d;

   logic dreq_gated, ireq_gated;
   logic gnt_dat, gnt_ins;

   // No grants until the first clock after reset release.
   assign dreq_gated = rdy_q & bus.d_req;
   assign ireq_gated = rdy_q & bus.i_req;

   sram_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
      .dreq_i    (dreq_gated),
      .ireq_i    (ireq_gated),
      .streak_i  (streak_q),
      .gnt_dat_o (gnt_dat),
      .gnt_ins_o (gnt_ins)
   );

   logic [REQ_W-1:0] d_bus, i_bus, sel_bus;

   assign d_bus = {bus.d_req, bus.d_we, bus.d_addr, bus.d_wdata};
   assign i_bus = {bus.i_req, {WE_W{1'b0}}, bus.i_addr, {DATA_W{1'b0}}};

   always_comb begin
      sel_bus = '0;
      if (gnt_dat)      sel_bus = d_bus;
      else if (gnt_ins) sel_bus = i_bus;
   end

   // The req bit of the selected bus doubles as the SRAM enable.
   assign bus.sram_en    = sel_bus[REQ_W-1];
   assign bus.sram_we    = sel_bus[REQ_W-2 -: WE_W];
   assign bus.sram_addr  = sel_bus[ADDR_W+DATA_W-1 -: ADDR_W];
   assign bus.sram_wdata = sel_bus[DATA_W-1:0];

   assign bus.i_addr_ok    = gnt_ins;
   assign bus.d_addr_ok    = gnt_dat;
   assign bus.i_data_ok    = resp_vld_q && (resp_src_q == SRC_INST);
   assign bus.d_data_ok    = resp_vld_q && (resp_src_q == SRC_DATA);
   assign bus.i_rdata      = bus.sram_rdata;
   assign bus.d_rdata      = bus.sram_rdata;
   assign bus.conflict_cnt = conflict_q;

   always_comb begin
      rdy_d      = 1'b1;
      resp_vld_d = gnt_dat | gnt_ins;
      resp_src_d = gnt_dat ? SRC_DATA : SRC_INST;
      streak_d   = streak_q;
      if (gnt_ins || !bus.i_req)
         streak_d = '0;
      else if (gnt_dat && streak_q < LIMIT)
         streak_d = streak_q + 1'b1;
      conflict_d = conflict_q;
      if (rdy_q && bus.i_req && bus.d_req)
         conflict_d = conflict_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_q      <= 1'b0;
         resp_vld_q <= 1'b0;
         resp_src_q <= SRC_INST;
         streak_q   <= '0;
         conflict_q <= '0;
      end else begin
         rdy_q      <= rdy_d;
         resp_vld_q <= resp_vld_d;
         resp_src_q <= resp_src_d;
         streak_q   <= streak_d;
         conflict_q <= conflict_d;
      end
   end
endmodule
